// File: rtl/matmul_sched_pkg.sv
// rtl/matmul_sched_pkg.sv - shared types, control-word layout and helpers for the matmul job scheduler
package matmul_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_WAIT_BUS,
        ST_PROGRAM,
        ST_RUN,
        ST_ABORT,
        ST_RETIRE
    } state_t;

    localparam logic [31:0] CTRL_ADDR = 32'h0;

    localparam int START_BIT = 0;
    localparam int MODE_BIT  = 1;
    localparam int TGT_LSB   = 2;
    localparam int N_LSB     = 8;
    localparam int K_LSB     = 10;
    localparam int M_LSB     = 12;

    localparam int DIM_W     = 2;
    localparam int JOB_TGT_W = 2;
    localparam int JOB_TAG_W = 4;

    typedef struct packed {
        logic [DIM_W-1:0]     n;
        logic [DIM_W-1:0]     k;
        logic [DIM_W-1:0]     m;
        logic                 mode;
        logic [JOB_TGT_W-1:0] tgt;
        logic [JOB_TAG_W-1:0] tag;
    } job_t;

    // Dim fields hold size-1, so a field is legal only while it stays below max_dim.
    function automatic logic dims_ok(job_t j, int max_dim);
        return (int'(j.n) < max_dim) && (int'(j.k) < max_dim) && (int'(j.m) < max_dim);
    endfunction

endpackage

// File: rtl/matmul_job_scheduler_if.sv
// rtl/matmul_job_scheduler_if.sv - job, arbitration, register-write and retire signals of the scheduler
interface matmul_job_scheduler_if #(
    parameter int BUS_WIDTH   = 16,
    parameter int ADDR_WIDTH  = 32,
    parameter int SP_NTARGETS = 4,
    parameter int JOB_DEPTH   = 4,
    parameter int TAG_WIDTH   = 4
);
    localparam int TW = (SP_NTARGETS > 1) ? $clog2(SP_NTARGETS) : 1;
    localparam int CW = $clog2(JOB_DEPTH) + 1;

    logic                  job_valid_i;
    logic                  job_ready_o;
    logic [1:0]            job_n_dim_i;
    logic [1:0]            job_k_dim_i;
    logic [1:0]            job_m_dim_i;
    logic                  job_mode_i;
    logic [TW-1:0]         job_sp_tgt_i;
    logic [TAG_WIDTH-1:0]  job_tag_i;
    logic                  apb_busy_i;
    logic                  finish_mul_i;
    logic                  cfg_we_o;
    logic [ADDR_WIDTH-1:0] cfg_addr_o;
    logic [BUS_WIDTH-1:0]  cfg_data_o;
    logic                  sched_busy_o;
    logic                  done_o;
    logic [TAG_WIDTH-1:0]  done_tag_o;
    logic                  done_err_o;
    logic [CW-1:0]         q_count_o;

    modport master (
        output job_valid_i, job_n_dim_i, job_k_dim_i, job_m_dim_i, job_mode_i,
               job_sp_tgt_i, job_tag_i, apb_busy_i, finish_mul_i,
        input  job_ready_o, cfg_we_o, cfg_addr_o, cfg_data_o, sched_busy_o,
               done_o, done_tag_o, done_err_o, q_count_o
    );

    modport slave (
        input  job_valid_i, job_n_dim_i, job_k_dim_i, job_m_dim_i, job_mode_i,
               job_sp_tgt_i, job_tag_i, apb_busy_i, finish_mul_i,
        output job_ready_o, cfg_we_o, cfg_addr_o, cfg_data_o, sched_busy_o,
               done_o, done_tag_o, done_err_o, q_count_o
    );

endinterface

// File: rtl/matmul_job_fifo.sv
// rtl/matmul_job_fifo.sv - synchronous job FIFO with occupancy count and registered ready
module matmul_job_fifo
    import matmul_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  job_t          job_i,
    input  logic          pop_i,
    output job_t          head_o,
    output logic [CW-1:0] count_o,
    output logic          ready_o
);
    localparam int AW = $clog2(DEPTH);

    job_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q, ready_d;
    logic          do_push, do_pop;

    assign do_push = push_i && ready_q;
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
        // Ready is registered so it stays low while reset is held and rises one cycle after release.
        ready_d = (count_d != CW'(DEPTH));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= job_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign ready_o = ready_q;

endmodule

// File: rtl/matmul_job_scheduler.sv
// rtl/matmul_job_scheduler.sv - queues matmul jobs and sequences them onto the engine via the control register
// Optional watchdog on the RUN state is enabled with MATMUL_SCHED_TIMEOUT_EN.
module matmul_job_scheduler
    import matmul_sched_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int BUS_WIDTH   = 16,
    parameter int ADDR_WIDTH  = 32,
    parameter int SP_NTARGETS = 4,
    parameter int JOB_DEPTH   = 4,
    parameter int TAG_WIDTH   = JOB_TAG_W
`ifdef MATMUL_SCHED_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 256
`endif
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    matmul_job_scheduler_if.slave  bus
);
    localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
    localparam int TW      = (SP_NTARGETS > 1) ? $clog2(SP_NTARGETS) : 1;
    localparam int CW      = $clog2(JOB_DEPTH) + 1;

    state_t                state_q;
    job_t                  in_job, head_job, job_q;
    logic                  fifo_pop, fifo_ready;
    logic [CW-1:0]         fifo_count;
    logic [BUS_WIDTH-1:0]  ctrl_word;
    logic                  cfg_we_q;
    logic [BUS_WIDTH-1:0]  cfg_data_q;
    logic                  done_q;
    logic [TAG_WIDTH-1:0]  done_tag_q;
    logic                  done_err_q;

`ifdef MATMUL_SCHED_TIMEOUT_EN
    localparam int TMW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMW-1:0] timer_q;
`endif

    always_comb begin
        in_job      = '0;
        in_job.n    = bus.job_n_dim_i;
        in_job.k    = bus.job_k_dim_i;
        in_job.m    = bus.job_m_dim_i;
        in_job.mode = bus.job_mode_i;
        in_job.tgt  = JOB_TGT_W'(bus.job_sp_tgt_i);
        in_job.tag  = JOB_TAG_W'(bus.job_tag_i);
    end

    assign fifo_pop = (state_q == ST_IDLE) && (fifo_count != '0);

    matmul_job_fifo #(
        .DEPTH (JOB_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (bus.job_valid_i),
        .job_i   (in_job),
        .pop_i   (fifo_pop),
        .head_o  (head_job),
        .count_o (fifo_count),
        .ready_o (fifo_ready)
    );

    // Start is always written as 1; the register file clears it when the engine finishes.
    always_comb begin
        ctrl_word                    = '0;
        ctrl_word[START_BIT]         = 1'b1;
        ctrl_word[MODE_BIT]          = job_q.mode;
        ctrl_word[TGT_LSB +: TW]     = job_q.tgt[TW-1:0];
        ctrl_word[N_LSB +: DIM_W]    = job_q.n;
        ctrl_word[K_LSB +: DIM_W]    = job_q.k;
        ctrl_word[M_LSB +: DIM_W]    = job_q.m;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            job_q      <= '0;
            cfg_we_q   <= 1'b0;
            cfg_data_q <= '0;
            done_q     <= 1'b0;
            done_tag_q <= '0;
            done_err_q <= 1'b0;
`ifdef MATMUL_SCHED_TIMEOUT_EN
            timer_q    <= '0;
`endif
        end else begin
            cfg_we_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (fifo_count != '0) begin
                        job_q   <= head_job;
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!dims_ok(job_q, MAX_DIM)) begin
                        done_q     <= 1'b1;
                        done_tag_q <= job_q.tag[TAG_WIDTH-1:0];
                        done_err_q <= 1'b1;
                        state_q    <= ST_RETIRE;
                    end else begin
                        state_q <= ST_WAIT_BUS;
                    end
                end
                // The only place the APB side is arbitrated against.
                ST_WAIT_BUS: begin
                    if (!bus.apb_busy_i) begin
                        cfg_we_q   <= 1'b1;
                        cfg_data_q <= ctrl_word;
                        state_q    <= ST_PROGRAM;
                    end
                end
                ST_PROGRAM: begin
                    state_q <= ST_RUN;
`ifdef MATMUL_SCHED_TIMEOUT_EN
                    timer_q <= '0;
`endif
                end
                ST_RUN: begin
                    if (bus.finish_mul_i) begin
                        done_q     <= 1'b1;
                        done_tag_q <= job_q.tag[TAG_WIDTH-1:0];
                        done_err_q <= 1'b0;
                        state_q    <= ST_RETIRE;
`ifdef MATMUL_SCHED_TIMEOUT_EN
                    end else if (timer_q == TMW'(TIMEOUT_CYCLES - 1)) begin
                        cfg_we_q   <= 1'b1;
                        cfg_data_q <= '0;
                        state_q    <= ST_ABORT;
                    end else begin
                        timer_q <= timer_q + 1'b1;
`endif
                    end
                end
                ST_ABORT: begin
                    done_q     <= 1'b1;
                    done_tag_q <= job_q.tag[TAG_WIDTH-1:0];
                    done_err_q <= 1'b1;
                    state_q    <= ST_RETIRE;
                end
                ST_RETIRE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.job_ready_o  = fifo_ready;
    assign bus.q_count_o    = fifo_count;
    assign bus.cfg_we_o     = cfg_we_q;
    assign bus.cfg_addr_o   = ADDR_WIDTH'(CTRL_ADDR);
    assign bus.cfg_data_o   = cfg_data_q;
    assign bus.sched_busy_o = (state_q != ST_IDLE);
    assign bus.done_o       = done_q;
    assign bus.done_tag_o   = done_tag_q;
    assign bus.done_err_o   = done_err_q;

endmodule

// File: tb/tb_matmul_job_scheduler.sv
// tb/tb_matmul_job_scheduler.sv - scoreboard bench for matmul_job_scheduler
module tb_matmul_job_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;

    matmul_job_scheduler_if #(
        .BUS_WIDTH(16), .ADDR_WIDTH(32), .SP_NTARGETS(4), .JOB_DEPTH(4), .TAG_WIDTH(4)
    ) bus ();

    matmul_job_scheduler #(
        .DATA_WIDTH(8), .BUS_WIDTH(16), .ADDR_WIDTH(32), .SP_NTARGETS(4), .JOB_DEPTH(4), .TAG_WIDTH(4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] cfg;
        logic [3:0]  tag;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    logic cfg_seen = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] n, input logic [1:0] k, input logic [1:0] m,
                                   input logic mode, input logic [1:0] tgt, input logic [3:0] tag);
        exp_t e;
        e.err = (n > 2'd1) || (k > 2'd1) || (m > 2'd1);
        e.cfg = {2'b00, m, k, n, 4'b0000, tgt, mode, 1'b1};
        e.tag = tag;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.cfg_we_o) begin
                if (sb.size() == 0) begin
                    check("cfg_unexpected", 1, 0);
                end else begin
                    check("cfg_data", bus.cfg_data_o, sb[0].cfg);
                    check("cfg_addr", bus.cfg_addr_o, 0);
                    check("cfg_for_err_job", sb[0].err, 0);
                    cfg_seen = 1'b1;
                end
            end
            if (bus.done_o) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_tag", bus.done_tag_o, e.tag);
                    check("done_err", bus.done_err_o, e.err);
                    check("cfg_written", cfg_seen, !e.err);
                    cfg_seen = 1'b0;
                end
                done_cnt++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_job(input logic [1:0] n, input logic [1:0] k, input logic [1:0] m,
                             input logic mode, input logic [1:0] tgt, input logic [3:0] tag,
                             output logic acc);
        bus.job_valid_i  = 1'b1;
        bus.job_n_dim_i  = n;
        bus.job_k_dim_i  = k;
        bus.job_m_dim_i  = m;
        bus.job_mode_i   = mode;
        bus.job_sp_tgt_i = tgt;
        bus.job_tag_i    = tag;
        acc = bus.job_ready_o;
        if (acc) sb.push_back(model(n, k, m, mode, tgt, tag));
        @(negedge clk);
    endtask

    task automatic wait_cfg(input int max, output int n);
        n = 0;
        while (!bus.cfg_we_o && n < max) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cfg_we_o) check("cfg_wait_timeout", bus.cfg_we_o, 1);
    endtask

    task automatic pulse_finish();
        bus.finish_mul_i = 1'b1;
        @(negedge clk);
        bus.finish_mul_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        logic acc;
        int   n;
        int   base;
        logic seen;

        bus.job_valid_i  = 1'b0;
        bus.job_n_dim_i  = '0;
        bus.job_k_dim_i  = '0;
        bus.job_m_dim_i  = '0;
        bus.job_mode_i   = 1'b0;
        bus.job_sp_tgt_i = '0;
        bus.job_tag_i    = '0;
        bus.apb_busy_i   = 1'b0;
        bus.finish_mul_i = 1'b0;

        tick(3);
        check("rst_ready", bus.job_ready_o, 0);
        check("rst_count", bus.q_count_o, 0);
        check("rst_busy", bus.sched_busy_o, 0);
        check("rst_outs", {bus.cfg_we_o, bus.done_o, bus.done_err_o, bus.done_tag_o, bus.cfg_data_o}, 0);
        rst = 1'b0;
        tick(1);
        check("ready_after_rst", bus.job_ready_o, 1);

        // Single valid job: latency to the control write and retire after finish.
        drive_job(2'd1, 2'd1, 2'd1, 1'b0, 2'd2, 4'd5, acc);
        bus.job_valid_i = 1'b0;
        check("single_acc", acc, 1);
        wait_cfg(20, n);
        check("cfg_latency", n, 3);
        tick(1);
        check("cfg_we_one_cycle", bus.cfg_we_o, 0);
        check("busy_in_run", bus.sched_busy_o, 1);
        tick(9);
        pulse_finish();
        check("done_after_finish", bus.done_o, 1);
        tick(1);
        check("done_one_cycle", bus.done_o, 0);
        check("idle_after_retire", bus.sched_busy_o, 0);
        check("done_tag_held", bus.done_tag_o, 5);

        // Finish outside RUN must not retire anything.
        base = done_cnt;
        pulse_finish();
        tick(3);
        check("finish_idle_ignored", done_cnt, base);

        // APB busy holds the scheduler in WAIT_BUS.
        bus.apb_busy_i = 1'b1;
        drive_job(2'd0, 2'd0, 2'd0, 1'b1, 2'd1, 4'd1, acc);
        bus.job_valid_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.cfg_we_o) seen = 1'b1;
        end
        check("no_cfg_while_apb_busy", seen, 0);
        check("busy_wait_bus", bus.sched_busy_o, 1);
        bus.apb_busy_i = 1'b0;
        tick(1);
        check("program_after_apb_idle", bus.cfg_we_o, 1);
        tick(2);
        bus.apb_busy_i = 1'b1;

        // Fill the queue behind the running job; tag 4 carries an illegal dim.
        for (int i = 0; i < 5; i++) begin
            drive_job((i == 2) ? 2'd3 : 2'd1, 2'd0, 2'(i % 2), 1'(i % 2), 2'(i), 4'(i + 2), acc);
            if (i == 3) check("ready_low_when_full", bus.job_ready_o, 0);
            if (i == 4) check("fifth_not_accepted", acc, 0);
        end
        bus.job_valid_i = 1'b0;
        check("count_full", bus.q_count_o, 4);

        // APB busy rising during RUN has no effect on finish.
        pulse_finish();
        check("finish_with_apb_busy", bus.done_o, 1);
        bus.apb_busy_i = 1'b0;

        for (int g = 0; g < 400 && sb.size() > 0; g++) begin
            @(negedge clk);
            if (bus.cfg_we_o) begin
                tick(2);
                pulse_finish();
            end
        end
        check("drain_empty", sb.size(), 0);
        check("retired_total", done_cnt, 6);
        check("count_drained", bus.q_count_o, 0);

        // Reset in RUN with two jobs queued drops everything.
        drive_job(2'd0, 2'd1, 2'd0, 1'b0, 2'd3, 4'd7, acc);
        bus.job_valid_i = 1'b0;
        wait_cfg(20, n);
        tick(1);
        drive_job(2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 4'd8, acc);
        drive_job(2'd1, 2'd1, 2'd1, 1'b1, 2'd1, 4'd9, acc);
        bus.job_valid_i = 1'b0;
        check("count_before_rst", bus.q_count_o, 2);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_count", bus.q_count_o, 0);
        check("rst_mid_busy", bus.sched_busy_o, 0);
        check("rst_mid_outs", {bus.cfg_we_o, bus.done_o, bus.done_err_o, bus.done_tag_o, bus.job_ready_o}, 0);
        sb.delete();
        cfg_seen = 1'b0;
        base = done_cnt;
        @(negedge clk);
        rst = 1'b0;
        tick(30);
        check("no_done_after_rst", done_cnt, base);
        check("ready_after_mid_rst", bus.job_ready_o, 1);
        check("idle_after_mid_rst", bus.sched_busy_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
